cpu_ctrl_ws: RTL

- Next-generation multicycle control FSM for the 8-bit RISC CPU.
- Decodes the 16-op instruction set and sequences ROM/RAM/register/accumulator/PC enables.
- Adds parametrised memory wait states with ready handshakes, a one-time opcode latch and halt/status outputs.
- Sits between the IR and the datapath; a drop-in successor of the current controller, with added ports.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_wait_ctr.sv | 28 ++
 rtl/cpu_ctrl_ws.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, state and fetch encodings for the cpu_ctrl_ws multicycle controller.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h3;
    localparam logic [3:0] OP_PRE = 4'h4;
    localparam logic [3:0] OP_STO = 4'h5;
    localparam logic [3:0] OP_ADD = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SAR = 4'h9;
    localparam logic [3:0] OP_INV = 4'hA;
    localparam logic [3:0] OP_AND = 4'hB;
    localparam logic [3:0] OP_OR  = 4'hC;
    localparam logic [3:0] OP_XOR = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] FETCH_NONE = 2'b00;
    localparam logic [1:0] FETCH_IR   = 2'b01;
    localparam logic [1:0] FETCH_OPND = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'h0,
        S_FETCH  = 4'h1,
        S_DECODE = 4'h2,
        S_OPND   = 4'h3,
        S_MEM_RD = 4'h4,
        S_ST_RD  = 4'h5,
        S_ST_WR  = 4'h6,
        S_JUMP   = 4'h7,
        S_EXEC   = 4'h8,
        S_WB_ACC = 4'h9,
        S_HALT   = 4'hA,
        S_PAUSE  = 4'hB
    } state_t;

    // Long ops carry an operand byte and so need the OPND fetch.
    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/cpu_wait_ctr.sv
// Memory wait-state counter shared by every memory state of cpu_ctrl_ws.
module cpu_wait_ctr #(
    parameter int WS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            rdy,
    output logic            done
);

    logic [WS_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A ready seen before the count expires is deliberately not remembered.
    assign done = (cnt == '0) && rdy;

endmodule

// File: rtl/cpu_ctrl_ws.sv
// Multicycle control FSM with memory wait states; define CPU_CTRL_DEBUG_STEP_EN
// to add the dbg_halt/dbg_step single-step ports and the PAUSE state.
module cpu_ctrl_ws
    import cpu_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int WS_W   = 4,
    parameter int ROM_WS = 0,
    parameter int RAM_WS = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] ins,
    input  logic            rom_rdy,
    input  logic            ram_rdy,
`ifdef CPU_CTRL_DEBUG_STEP_EN
    input  logic            dbg_halt,
    input  logic            dbg_step,
`endif
    output logic            write_r,
    output logic            read_r,
    output logic            pc_en,
    output logic            pc_chg_en,
    output logic [1:0]      fetch,
    output logic            ac_ena,
    output logic            rom_ena,
    output logic            rom_read,
    output logic            ram_ena,
    output logic            ram_read,
    output logic            ram_write,
    output logic            ad_sel,
    output logic            halted,
    output logic [3:0]      state_o
);

    localparam logic [WS_W-1:0] ROM_CNT = WS_W'(ROM_WS);
    localparam logic [WS_W-1:0] RAM_CNT = WS_W'(RAM_WS);

    state_t      state;
    state_t      nxt;
    logic [3:0]  op_q;
    logic [3:0]  ins_op;
    logic        use_ram;
    logic        wait_rdy;
    logic        done;
    logic        ctr_load;
    logic [WS_W-1:0] ctr_val;

    // Opcodes wider than the defined set behave as a plain ALU op.
    assign ins_op   = ((ins >> 4) == '0) ? ins[3:0] : OP_ADD;
    assign use_ram  = (state == S_ST_WR) || ((state == S_MEM_RD) && (op_q != OP_LDO));
    assign wait_rdy = use_ram ? ram_rdy : rom_rdy;
    assign state_o  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                op_q <= ins_op;
            end
        end
    end

    always_comb begin
        nxt       = state;
        write_r   = 1'b0;
        read_r    = 1'b0;
        pc_en     = 1'b0;
        pc_chg_en = 1'b0;
        fetch     = FETCH_NONE;
        ac_ena    = 1'b0;
        rom_ena   = 1'b0;
        rom_read  = 1'b0;
        ram_ena   = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ad_sel    = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                rom_ena  = 1'b1;
                rom_read = 1'b1;
                fetch    = FETCH_IR;
                if (done) nxt = S_DECODE;
            end
            S_DECODE: begin
                pc_en    = 1'b1;
                rom_ena  = 1'b1;
                rom_read = 1'b1;
                if (ins_op == OP_NOP)      nxt = S_FETCH;
                else if (ins_op == OP_HLT) nxt = S_HALT;
                else if (ins_op == OP_LDR) nxt = S_WB_ACC;
                else if (is_long(ins_op))  nxt = S_OPND;
                else                       nxt = S_EXEC;
            end
            S_OPND: begin
                rom_ena  = 1'b1;
                rom_read = 1'b1;
                fetch    = FETCH_OPND;
                if (done) begin
                    pc_en = 1'b1;
                    if ((op_q == OP_LDO) || (op_q == OP_LDA)) nxt = S_MEM_RD;
                    else if (op_q == OP_STO)                  nxt = S_ST_RD;
                    else                                      nxt = S_JUMP;
                end
            end
            S_MEM_RD: begin
                write_r = 1'b1;
                ad_sel  = 1'b1;
                if (op_q == OP_LDO) begin
                    rom_ena  = 1'b1;
                    rom_read = 1'b1;
                end else begin
                    ram_ena  = 1'b1;
                    ram_read = 1'b1;
                end
                if (done) nxt = S_FETCH;
            end
            S_ST_RD: begin
                read_r = 1'b1;
                nxt    = S_ST_WR;
            end
            S_ST_WR: begin
                read_r    = 1'b1;
                ram_ena   = 1'b1;
                ram_write = 1'b1;
                ad_sel    = 1'b1;
                if (done) nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_chg_en = 1'b1;
                nxt       = S_FETCH;
            end
            S_EXEC: begin
                read_r = 1'b1;
                ac_ena = 1'b1;
                nxt    = S_FETCH;
            end
            S_WB_ACC: begin
                write_r = 1'b1;
                ac_ena  = 1'b1;
                nxt     = S_FETCH;
            end
            S_HALT: halted = 1'b1;
`ifdef CPU_CTRL_DEBUG_STEP_EN
            S_PAUSE: begin
                if (dbg_step || !dbg_halt) nxt = S_FETCH;
            end
`endif
            default: nxt = S_IDLE;
        endcase
`ifdef CPU_CTRL_DEBUG_STEP_EN
        // Divert every fresh entry into FETCH, but let PAUSE release one instruction.
        if ((nxt == S_FETCH) && (state != S_FETCH) && (state != S_PAUSE) && dbg_halt) begin
            nxt = S_PAUSE;
        end
`endif
    end

    // The counter is reloaded only when a memory state is newly entered.
    always_comb begin
        ctr_load = 1'b0;
        ctr_val  = '0;
        if (nxt != state) begin
            case (nxt)
                S_FETCH, S_OPND: begin
                    ctr_load = 1'b1;
                    ctr_val  = ROM_CNT;
                end
                S_MEM_RD: begin
                    ctr_load = 1'b1;
                    ctr_val  = (op_q == OP_LDO) ? ROM_CNT : RAM_CNT;
                end
                S_ST_WR: begin
                    ctr_load = 1'b1;
                    ctr_val  = RAM_CNT;
                end
                default: ;
            endcase
        end
    end

    cpu_wait_ctr #(
        .WS_W(WS_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_val),
        .rdy      (wait_rdy),
        .done     (done)
    );

endmodule
